// File: rtl/reg_file_if.sv
// Register-file access bundle: two operand read ports, one writeback port and a debug read port.
interface reg_file_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] rs1_addr;
    logic [ADDR_W-1:0] rs2_addr;
    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;
    logic              we;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_data;

    modport master (
        output rs1_addr, rs2_addr, we, rd_addr, rd_data, dbg_addr,
        input  rs1_data, rs2_data, dbg_data
    );

    modport slave (
        input  rs1_addr, rs2_addr, we, rd_addr, rd_data, dbg_addr,
        output rs1_data, rs2_data, dbg_data
    );
endinterface

// File: rtl/reg_file.sv
// 32 x 32 integer register file: x0 hardwired to zero, three combinational reads, one write port.
// Optional write-through bypass on all read ports when REGFILE_BYPASS_EN is defined.
module reg_file #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    reg_file_if.slave  bus
);
    logic [DATA_W-1:0] w_regs [NUM_REGS];

    assign w_regs[0] = '0;

    // One flop bank per architectural register; the address compare never matches x0.
    generate
        for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_reg
            logic [DATA_W-1:0] r_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_q <= '0;
                end else if (bus.we && (bus.rd_addr == ADDR_W'(gi))) begin
                    r_q <= bus.rd_data;
                end
            end

            assign w_regs[gi] = r_q;
        end
    endgenerate

`ifdef REGFILE_BYPASS_EN
    logic w_wr_valid;
    logic w_hit_rs1;
    logic w_hit_rs2;
    logic w_hit_dbg;

    assign w_wr_valid = bus.we && (bus.rd_addr != '0);
    assign w_hit_rs1  = w_wr_valid && (bus.rs1_addr == bus.rd_addr);
    assign w_hit_rs2  = w_wr_valid && (bus.rs2_addr == bus.rd_addr);
    assign w_hit_dbg  = w_wr_valid && (bus.dbg_addr == bus.rd_addr);

    assign bus.rs1_data = w_hit_rs1 ? bus.rd_data : w_regs[bus.rs1_addr];
    assign bus.rs2_data = w_hit_rs2 ? bus.rd_data : w_regs[bus.rs2_addr];
    assign bus.dbg_data = w_hit_dbg ? bus.rd_data : w_regs[bus.dbg_addr];
`else
    assign bus.rs1_data = w_regs[bus.rs1_addr];
    assign bus.rs2_data = w_regs[bus.rs2_addr];
    assign bus.dbg_data = w_regs[bus.dbg_addr];
`endif

endmodule

// File: tb/tb_reg_file.sv
// Directed testbench for reg_file: reset, writes, x0 discard, same-cycle read/write, async reset.
module tb_reg_file;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    reg_file_if #(.DATA_W(32), .ADDR_W(5)) bus_if ();

    reg_file #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
            $display("check %s observed=%h expected=%h ok", tag, obs, exp);
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        bus_if.we      = 1'b1;
        bus_if.rd_addr = a;
        bus_if.rd_data = d;
        tick();
        bus_if.we      = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus_if.rs1_addr = '0;
        bus_if.rs2_addr = '0;
        bus_if.dbg_addr = '0;
        bus_if.we       = 1'b0;
        bus_if.rd_addr  = '0;
        bus_if.rd_data  = '0;
        #12;
        rst_n = 1'b1;

        // Every address reads zero after reset on all three ports.
        for (int i = 0; i < 32; i++) begin
            bus_if.rs1_addr = 5'(i);
            bus_if.rs2_addr = 5'(31 - i);
            bus_if.dbg_addr = 5'(i);
            #1;
            check($sformatf("reset_rs1_x%0d", i), bus_if.rs1_data, 32'h0);
            check($sformatf("reset_rs2_x%0d", 31 - i), bus_if.rs2_data, 32'h0);
            check($sformatf("reset_dbg_x%0d", i), bus_if.dbg_data, 32'h0);
        end

        // ALU overflow operands on consecutive edges.
        wr(5'd5, 32'h7FFF_FFFF);
        wr(5'd6, 32'h0000_0001);
        bus_if.rs1_addr = 5'd5;
        bus_if.rs2_addr = 5'd6;
        bus_if.dbg_addr = 5'd5;
        #1;
        check("x5_rs1", bus_if.rs1_data, 32'h7FFF_FFFF);
        check("x6_rs2", bus_if.rs2_data, 32'h0000_0001);
        check("x5_dbg", bus_if.dbg_data, 32'h7FFF_FFFF);

        // Write to x0 is discarded and disturbs nothing else.
        wr(5'd0, 32'hDEAD_BEEF);
        bus_if.rs1_addr = 5'd0;
        bus_if.rs2_addr = 5'd5;
        bus_if.dbg_addr = 5'd6;
        #1;
        check("x0_after_write", bus_if.rs1_data, 32'h0);
        check("x5_after_x0_write", bus_if.rs2_data, 32'h7FFF_FFFF);
        check("x6_after_x0_write", bus_if.dbg_data, 32'h0000_0001);

        // Same-register read during write.
        wr(5'd10, 32'hF0F0_F0F0);
        bus_if.rs1_addr = 5'd10;
        bus_if.dbg_addr = 5'd10;
        bus_if.we       = 1'b1;
        bus_if.rd_addr  = 5'd10;
        bus_if.rd_data  = 32'h0F0F_0F0F;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("x10_rs1_pre_edge", bus_if.rs1_data, 32'h0F0F_0F0F);
        check("x10_dbg_pre_edge", bus_if.dbg_data, 32'h0F0F_0F0F);
`else
        check("x10_rs1_pre_edge", bus_if.rs1_data, 32'hF0F0_F0F0);
        check("x10_dbg_pre_edge", bus_if.dbg_data, 32'hF0F0_F0F0);
`endif
        tick();
        bus_if.we = 1'b0;
        #1;
        check("x10_rs1_post_edge", bus_if.rs1_data, 32'h0F0F_0F0F);

        // Write to x0 must never bypass.
        bus_if.rs1_addr = 5'd0;
        bus_if.we       = 1'b1;
        bus_if.rd_addr  = 5'd0;
        bus_if.rd_data  = 32'h1234_5678;
        #1;
        check("x0_no_bypass", bus_if.rs1_data, 32'h0);
        bus_if.we = 1'b0;

        // Both operand ports on the same index.
        bus_if.rs1_addr = 5'd5;
        bus_if.rs2_addr = 5'd5;
        #1;
        check("same_addr_rs1", bus_if.rs1_data, 32'h7FFF_FFFF);
        check("same_addr_rs2", bus_if.rs2_data, 32'h7FFF_FFFF);

        // we=0 leaves x31 untouched; we=1 writes it.
        bus_if.we       = 1'b0;
        bus_if.rd_addr  = 5'd31;
        bus_if.rd_data  = 32'h8000_0000;
        tick();
        bus_if.dbg_addr = 5'd31;
        #1;
        check("x31_we0", bus_if.dbg_data, 32'h0);
        wr(5'd31, 32'h8000_0000);
        #1;
        check("x31_we1", bus_if.dbg_data, 32'h8000_0000);

        // Fill x1..x31 with distinct nonzero values and read them back.
        for (int i = 1; i < 32; i++) wr(5'(i), 32'hA500_0000 | 32'(i));
        for (int i = 0; i < 32; i++) begin
            bus_if.dbg_addr = 5'(i);
            #1;
            check($sformatf("fill_dbg_x%0d", i), bus_if.dbg_data,
                  (i == 0) ? 32'h0 : (32'hA500_0000 | 32'(i)));
        end

        // Async reset between edges clears everything immediately.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 32; i += 4) begin
            bus_if.rs1_addr = 5'(i);
            bus_if.rs2_addr = 5'(i + 1);
            bus_if.dbg_addr = 5'(i + 2);
            #1;
            check($sformatf("async_rst_rs1_x%0d", i), bus_if.rs1_data, 32'h0);
            check($sformatf("async_rst_rs2_x%0d", i + 1), bus_if.rs2_data, 32'h0);
            check($sformatf("async_rst_dbg_x%0d", i + 2), bus_if.dbg_data, 32'h0);
        end

        // A write on an edge while reset is held is lost.
        bus_if.we       = 1'b1;
        bus_if.rd_addr  = 5'd7;
        bus_if.rd_data  = 32'h1234_5678;
        tick();
        bus_if.we       = 1'b0;
        rst_n           = 1'b1;
        bus_if.rs1_addr = 5'd7;
        bus_if.dbg_addr = 5'd31;
        #1;
        check("x7_write_during_reset", bus_if.rs1_data, 32'h0);
        check("x31_after_reset", bus_if.dbg_data, 32'h0);

        // Normal writes resume after reset release.
        wr(5'd7, 32'hCAFE_F00D);
        #1;
        check("x7_after_release", bus_if.rs1_data, 32'hCAFE_F00D);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
